// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed multi-digit 7-segment driver with double buffering, leading-zero blanking and blink
// Ports: clk, rst (sync, active-high); digits_in (BCD, [3:0] = digit 0); load (capture strobe);
//   blank_lz (blank leading zeros); blink_en (blink whole display);
//   seg_out {g,f,e,d,c,b,a} active-low; an_out active-low digit enables; frame_done (1-cycle end-of-frame pulse).
// Build option: define SEG7_HEX_EN to show codes 10-15 as A b C d E F; otherwise they are blanked.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 2,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         act_q, act_d, pend_q, pend_d;
  logic                  pv_q, pv_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  boff_q, boff_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;
  logic                  tick, last, xfer, dark, blank, bwrap;
  logic [3:0]            cur;
  logic [NUM_DIGITS:0]   zf;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
`ifdef SEG7_HEX_EN
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      4'hF: dec = 7'h0E;
`endif
      default: dec = 7'h7F;
    endcase
  endfunction

  always_comb begin
    tick = pre_q == PW'(SCAN_DIV - 1);
    last = idx_q == IW'(NUM_DIGITS - 1);
    xfer = tick & last & pv_q;
    // zf[k]: every active digit from the most significant down to k is zero
    zf[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) zf[k] = zf[k+1] & (act_q[4*k +: 4] == 4'd0);
    cur    = act_q[{idx_q, 2'b00} +: 4];
    dark   = blink_en & boff_q;
    blank  = dark | (blank_lz & (idx_q != '0) & zf[idx_q]);
    pre_d  = tick ? '0 : pre_q + 1'b1;
    idx_d  = tick ? (last ? '0 : idx_q + 1'b1) : idx_q;
    seg_d  = tick ? (blank ? 7'h7F : dec(cur)) : seg_q;
    an_d   = tick ? (dark ? '1 : ~(NUM_DIGITS'(1) << idx_q)) : an_q;
    fd_d   = tick & last;
    // transfer uses the old pending value; a load on the same edge stays pending
    act_d  = xfer ? pend_q : act_q;
    pend_d = load ? digits_in : pend_q;
    pv_d   = load | (pv_q & ~xfer);
    bwrap  = bcnt_q == BW'(BLINK_FRAMES - 1);
    bcnt_d = !blink_en ? '0 : fd_q ? (bwrap ? '0 : bcnt_q + 1'b1) : bcnt_q;
    boff_d = blink_en & ((fd_q & bwrap) ? ~boff_q : boff_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      idx_q  <= '0;
      act_q  <= '0;
      pend_q <= '0;
      pv_q   <= 1'b0;
      bcnt_q <= '0;
      boff_q <= 1'b0;
      seg_q  <= 7'h7F;
      an_q   <= '1;
      fd_q   <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      bcnt_q <= bcnt_d;
      boff_q <= boff_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      fd_q   <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver (NUM_DIGITS=2, SCAN_DIV=4, BLINK_FRAMES=2)
module tb_seg7_scan_driver;
  localparam int N = 2, SD = 4, BF = 2;

  logic       clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0, blink_en = 1'b0;
  logic [7:0] digits_in = '0;
  logic [6:0] seg_out;
  logic [1:0] an_out;
  logic       frame_done;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .blank_lz(blank_lz),
    .blink_en(blink_en), .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
  );

  int         tests = 0, fails = 0;
  logic [8:0] q[$];
  logic [8:0] last_exp;
  logic [6:0] tbl[16];
  bit         mon_en = 0;
  int         m_pre, m_idx, m_cnt;
  logic [7:0] m_act, m_pend;
  bit         m_pv, m_fd, m_off, m_tick, m_lz, m_fdn;
  logic [3:0] m_d;

  initial begin
`ifdef SEG7_HEX_EN
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: pushes the expected {an_out, seg_out} on every scan tick
  always @(posedge clk) begin
    if (rst) begin
      m_pre = 0; m_idx = 0; m_cnt = 0; m_act = 0; m_pend = 0;
      m_pv = 0; m_fd = 0; m_off = 0;
      q.delete();
      last_exp = {2'b11, 7'h7F};
      mon_en = 1;
    end else begin
      m_tick = (m_pre == SD - 1);
      m_pre  = m_tick ? 0 : m_pre + 1;
      m_fdn  = 0;
      if (m_tick) begin
        m_d  = m_act[4*m_idx +: 4];
        m_lz = blank_lz && m_idx > 0;
        for (int k = m_idx; k < N; k++) if (m_act[4*k +: 4] != 4'd0) m_lz = 0;
        if (blink_en && m_off) q.push_back({2'b11, 7'h7F});
        else q.push_back({~(2'b01 << m_idx), m_lz ? 7'h7F : tbl[m_d]});
        if (m_idx == N - 1) begin
          m_fdn = 1;
          if (m_pv) begin m_act = m_pend; m_pv = 0; end
          m_idx = 0;
        end else m_idx++;
      end
      if (load) begin m_pend = digits_in; m_pv = 1; end
      if (!blink_en) begin m_cnt = 0; m_off = 0; end
      else if (m_fd) begin
        if (m_cnt == BF - 1) begin m_cnt = 0; m_off = !m_off; end
        else m_cnt++;
      end
      m_fd = m_fdn;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0) last_exp = q.pop_front();
      check("an_out", an_out, last_exp[8:7]);
      check("seg_out", seg_out, last_exp[6:0]);
      check("frame_done", frame_done, m_fd);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    digits_in = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // align so the next rising edge is the end-of-frame transfer tick
  task automatic wait_xfer();
    for (int i = 0; i < 64 && !(m_pre == SD - 1 && m_idx == N - 1); i++) @(negedge clk);
    if (!(m_pre == SD - 1 && m_idx == N - 1)) begin
      tests++;
      fails++;
      $display("FAIL xfer_align timeout pre=%0d idx=%0d", m_pre, m_idx);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_load(8'h37);
    cycles(40);
    blank_lz = 1'b1;
    do_load(8'h05);
    cycles(24);
    do_load(8'h00);
    cycles(24);
    blank_lz = 1'b0;
    do_load(8'h12);
    cycles(2);
    do_load(8'h34);
    wait_xfer();
    do_load(8'h56);
    cycles(32);
    do_load(8'h99);
    cycles(20);
    blink_en = 1'b1;
    cycles(80);
    blink_en = 1'b0;
    cycles(24);
    do_load(8'h0A);
    cycles(24);
    do_load(8'hFB);
    cycles(24);
    do_load(8'hCD);
    cycles(24);
    blank_lz = 1'b1;
    do_load(8'h0E);
    cycles(24);
    for (int i = 0; i < 8; i++) begin
      blank_lz = 1'($urandom);
      blink_en = 1'($urandom);
      do_load(8'($urandom));
      cycles($urandom_range(3, 30));
    end
    blank_lz = 1'b0;
    blink_en = 1'b0;
    do_load(8'h77);
    cycles(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycles(24);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
